mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one memory bus (valid/instr/addr/wdata/wstrb -> rdata/ready) between two requesters:
//   m0 = CPU, m1 = secondary master (loader/DMA). Sits between the masters and the address
//   decoder that fans out to bram/uart/timer. Round-robin grant; hung slaves are caught by a
//   timeout that returns an error response.
// PARAMETERS
//   TIMEOUT   1024          cycles a granted transfer may wait for mem_ready (>=2)
//   ERR_DATA  32'hDEADBEEF  rdata returned to the master on timeout
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   asynchronous, active-high reset
//   m0_valid     in   1   m0 request; held with fields stable until m0_ready
//   m0_instr     in   1   m0 fetch qualifier
//   m0_addr      in   32  m0 byte address
//   m0_wdata     in   32  m0 write data
//   m0_wstrb     in   4   m0 byte strobes; 0 = read
//   m0_rdata     out  32  m0 read data, valid only with m0_ready
//   m0_ready     out  1   m0 completion, 1-cycle pulse
//   m1_*         --   --  identical set for m1 (valid,instr,addr,wdata,wstrb,rdata,ready)
//   mem_valid    out  1   request to downstream bus
//   mem_instr    out  1   forwarded instr of granted master
//   mem_addr     out  32  forwarded addr
//   mem_wdata    out  32  forwarded wdata
//   mem_wstrb    out  4   forwarded wstrb
//   mem_rdata    in   32  downstream read data
//   mem_ready    in   1   downstream completion pulse
//   bus_err      out  1   1-cycle pulse on timeout
//   bus_err_id   out  1   master that timed out (held until next error)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-transfer): state=IDLE, last=1, cnt=0, bus_err_id=0;
//     all outputs 0. Aborted transfer is never acknowledged.
//   - FSM: IDLE, BUSY0, BUSY1, TOUT.
//   - IDLE: mem_valid=0, mem_* fields=0. If only mX_valid -> BUSYX. If both -> grant
//     master != last. Grant registered: last<=X, cnt<=0. mem_ready seen in IDLE is ignored.
//   - BUSYX: mem_valid=mX_valid, mem_* = mX_* (combinational pass-through).
//     mem_ready=1 -> mX_ready=1, mX_rdata=mem_rdata same cycle; next state IDLE.
//     mX_valid=0 (protocol violation) -> IDLE, no ready.
//     else cnt<=cnt+1; when cnt==TIMEOUT-1 and no mem_ready -> TOUT.
//   - TOUT (1 cycle): mem_valid=0, mX_ready=1, mX_rdata=ERR_DATA, bus_err=1,
//     bus_err_id<=X; next IDLE. Late mem_ready for aborted transfer is dropped.
//   - Non-granted master: ready=0, rdata=0; its request waits (no drop, no reorder).
//   - Latency: request in IDLE at cycle n -> mem_valid at n+1; zero-wait slave -> mX_ready at
//     n+1. Min 1 IDLE cycle between transfers (peak 1 transfer / 2 cycles).
//   - mem_ready and timeout in same cycle: mem_ready wins (normal completion, no error).
//   - Fairness: with both requesting continuously, grants strictly alternate; max wait for
//     either master = one transfer of the other + 1 cycle.
//   - cnt width $clog2(TIMEOUT)+1; never wraps (cleared on grant).
//   - mX_rdata is 0 whenever mX_ready=0.
// TESTING
//   1. Reset, m0 read addr=0x100, slave ready 1 cycle after mem_valid -> mem_addr=0x100,
//      m0_ready pulse with rdata from slave, m1_ready never asserts.
//   2. m0,m1 assert valid same cycle after reset -> m0 granted first, then m1; with both held
//      for 6 transfers grant order 0,1,0,1,0,1.
//   3. Slave never readies, TIMEOUT=16 -> m1 write: m1_ready with rdata=32'hDEADBEEF exactly
//      17 cycles after mem_valid rises, bus_err pulse, bus_err_id=1, mem_valid low in TOUT.
//   4. mem_ready on cycle cnt==TIMEOUT-1 -> normal completion, bus_err stays 0.
//   5. Assert rst while BUSY0 with slave stalled -> all outputs 0 immediately (async),
//      m0_ready never pulses; after release next request granted normally.
//   6. Stray mem_ready in IDLE and after TOUT -> no mX_ready, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus, with a
// watchdog that answers a hung slave with an error response.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        bus_err_id
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, TOUT} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          gnt_valid;

  // Request line of whichever master currently owns the bus
  assign gnt_valid = (state == BUSY1) ? m1_valid : m0_valid;

  // Grant, completion and watchdog state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cnt        <= '0;
      bus_err_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last)) begin
            state <= BUSY0;
            last  <= 1'b0;
            cnt   <= '0;
          end else if (m1_valid) begin
            state <= BUSY1;
            last  <= 1'b1;
            cnt   <= '0;
          end
        end
        BUSY0, BUSY1: begin
          if (mem_ready) begin
            state <= IDLE;
          end else if (!gnt_valid) begin
            state <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= TOUT;
            bus_err_id <= last;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TOUT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus pass-through for the granted master and response steering
  always_comb begin
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    bus_err   = 1'b0;
    case (state)
      BUSY0: begin
        mem_valid = m0_valid;
        mem_instr = m0_instr;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
        m0_ready  = mem_ready;
        m0_rdata  = mem_ready ? mem_rdata : '0;
      end
      BUSY1: begin
        mem_valid = m1_valid;
        mem_instr = m1_instr;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
        m1_ready  = mem_ready;
        m1_rdata  = mem_ready ? mem_rdata : '0;
      end
      TOUT: begin
        bus_err = 1'b1;
        if (last) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_DATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_DATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transfers, alternation under
// contention, async reset mid-transfer, stray slave responses.
module tb_mem_arbiter;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_err, bus_err_id;

  mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_err(bus_err), .bus_err_id(bus_err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [3:0]  ws;
    int          delay;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  int          order_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          last_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave data model: depends only on the address it was given
  function automatic logic [31:0] slave_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic drive(input int x, input logic v, input logic [31:0] a, input logic [3:0] ws);
    if (x == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = v ? ~a : 32'h0; m0_wstrb = ws;
      m0_instr = v && (ws == 4'h0);
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = v ? ~a : 32'h0; m1_wstrb = ws;
      m1_instr = v && (ws == 4'h0);
    end
  endtask

  // Master and slave models; each cycle starts just after a falling edge
  task automatic run(input int n0, input int n1, input int delay,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [3:0] ws, input int budget);
    int          rem[2];
    bit          act[2];
    logic [31:0] cur[2];
    int          k[2];
    int          lat;
    int          vcnt;
    bit          started;
    bit          tmo;
    bit          done;
    exp_t        e;
    rem[0] = n0; rem[1] = n1;
    act[0] = 0;  act[1] = 0;
    k[0] = 0;    k[1] = 0;
    cur[0] = 0;  cur[1] = 0;
    lat = 0; vcnt = 0; started = 0; done = 0;
    tmo = (delay < 0) || (delay >= int'(TO));
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (!act[x]) begin
          if (rem[x] > 0) begin
            rem[x]--;
            act[x] = 1;
            cur[x] = ((x == 0) ? a0 : a1) + 32'(k[x] * 4);
            k[x]++;
            e.rdata = tmo ? ERR : slave_fn(cur[x]);
            e.err   = tmo;
            e.lat   = tmo ? int'(TO) + 1 : delay + 1;
            if (x == 0) sb0.push_back(e); else sb1.push_back(e);
            drive(x, 1'b1, cur[x], ws);
          end else begin
            drive(x, 1'b0, 32'h0, 4'h0);
          end
        end
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      #1;
      if (mem_valid) begin
        if (!started) begin
          started = 1;
          lat = 0;
          vcnt = 0;
        end
        chk("mem_addr_fwd", 32'((act[0] && mem_addr == cur[0]) || (act[1] && mem_addr == cur[1])), 32'd1);
        chk("mem_wdata_fwd", mem_wdata, ~mem_addr);
        chk("mem_wstrb_fwd", 32'(mem_wstrb), 32'(ws));
        chk("mem_instr_fwd", 32'(mem_instr), 32'(ws == 4'h0));
        if (delay >= 0 && vcnt == delay) begin
          mem_ready = 1'b1;
          mem_rdata = slave_fn(mem_addr);
        end
        vcnt++;
      end
      if (started) lat++;
      #1;
      if (m0_ready || m1_ready) begin
        int x;
        x = m1_ready ? 1 : 0;
        chk("single_ready", 32'(m0_ready & m1_ready), 32'd0);
        chk("ready_only_if_requesting", 32'(act[x]), 32'd1);
        chk("other_rdata_zero", (x == 0) ? m1_rdata : m0_rdata, 32'h0);
        if (((x == 0) ? sb0.size() : sb1.size()) > 0) begin
          e = (x == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("rdata", (x == 0) ? m0_rdata : m1_rdata, e.rdata);
          chk("bus_err", 32'(bus_err), 32'(e.err));
          chk("latency", 32'(lat), 32'(e.lat));
          if (e.err) chk("tout_mem_valid", 32'(mem_valid), 32'd0);
        end else begin
          chk("scoreboard_empty_on_ready", 32'(sb0.size() + sb1.size()), 32'd1);
        end
        last_rdata = (x == 0) ? m0_rdata : m1_rdata;
        last_err   = bus_err;
        last_lat   = lat;
        last_m     = x;
        order_q.push_back(x);
        act[x]  = 0;
        started = 0;
        done = (rem[0] == 0) && (rem[1] == 0) && !act[0] && !act[1];
      end else begin
        chk("no_ready_no_err", 32'(bus_err), 32'd0);
        chk("rdata_zero_no_ready", m0_rdata | m1_rdata, 32'h0);
      end
      @(negedge clk);
    end
    chk("run_completed_in_budget", 32'(done), 32'd1);
    drive(0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 4'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic exp_id;
    int   exp_order[6];
    vecs[0] = '{m: 1'b0, addr: 32'h0000_0100, ws: 4'h0, delay: 1,  exp_rdata: 32'h0100FEFF, exp_err: 1'b0, exp_lat: 2};
    vecs[1] = '{m: 1'b1, addr: 32'h2000_0204, ws: 4'hF, delay: 0,  exp_rdata: 32'h0204FDFB, exp_err: 1'b0, exp_lat: 1};
    vecs[2] = '{m: 1'b0, addr: 32'h0000_0008, ws: 4'h3, delay: 15, exp_rdata: 32'h0008FFF7, exp_err: 1'b0, exp_lat: 16};
    vecs[3] = '{m: 1'b1, addr: 32'h0000_0040, ws: 4'h8, delay: -1, exp_rdata: 32'hDEADBEEF, exp_err: 1'b1, exp_lat: 17};
    vecs[4] = '{m: 1'b0, addr: 32'h0000_0044, ws: 4'h0, delay: 16, exp_rdata: 32'hDEADBEEF, exp_err: 1'b1, exp_lat: 17};
    vecs[5] = '{m: 1'b1, addr: 32'h0000_3000, ws: 4'h0, delay: 4,  exp_rdata: 32'h3000CFFF, exp_err: 1'b0, exp_lat: 5};
    exp_order = '{0, 1, 0, 1, 0, 1};

    rst = 1'b1;
    drive(0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 4'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_bus_err_id", 32'(bus_err_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single transfers from the vector table
    exp_id = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].m ? 0 : 1, vecs[i].m ? 1 : 0, vecs[i].delay,
          vecs[i].addr, vecs[i].addr, vecs[i].ws, 60);
      if (vecs[i].exp_err) exp_id = vecs[i].m;
      chk($sformatf("vec%0d_master", i), 32'(last_m), 32'(vecs[i].m));
      chk($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(last_lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_err_id", i), 32'(bus_err_id), 32'(exp_id));
    end

    // Stray mem_ready right after a timeout, then in plain IDLE
    run(1, 0, -1, 32'h0000_0500, 32'h0, 4'h0, 60);
    chk("tout_err_id", 32'(bus_err_id), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    #2;
    chk("stray_after_tout_ready", 32'({m0_ready, m1_ready}), 32'd0);
    chk("stray_after_tout_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    #2;
    chk("stray_idle_ready", 32'({m0_ready, m1_ready}), 32'd0);
    chk("stray_idle_rdata", m0_rdata | m1_rdata, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    chk("stray_idle_state", 32'(mem_valid), 32'd0);
    @(negedge clk);
    run(0, 1, 2, 32'h0, 32'h0000_0600, 4'h0, 60);
    chk("after_stray_lat", 32'(last_lat), 32'd3);

    // Async reset while m0 is stalled on the bus
    drive(0, 1'b1, 32'h0000_0300, 4'h0);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(mem_valid), 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h0000_0300);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_m0_ready", 32'(m0_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h2222_2222;
      #1;
      chk("in_rst_m0_ready", 32'(m0_ready), 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    drive(0, 1'b0, 32'h0, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: grants alternate starting with m0
    order_q.delete();
    run(3, 3, 0, 32'h0000_1000, 32'h0000_2000, 4'h0, 60);
    chk("order_len", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < order_q.size(); i++)
      chk($sformatf("grant_order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));
    chk("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
